fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, drives a synchronous 1-cycle-latency

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_skid_buffer.sv | 46 ++++
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the reset PC default, FSM state encoding and instruction field positions.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    localparam word_t DefaultResetPc = 32'h0000_0000;

    typedef enum logic {
        FsRun  = 1'b0,
        FsHold = 1'b1
    } fetch_state_e;

    localparam int unsigned OpcodeLsb = 26;
    localparam int unsigned RsLsb     = 21;
    localparam int unsigned RtLsb     = 16;
    localparam int unsigned RdLsb     = 11;
    localparam int unsigned ShamtLsb  = 6;

    function automatic word_t pc_inc(input word_t pc_in);
        return pc_in + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction RAM port: synchronous read, data returned the cycle after imem_en.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  imem_en;
    word_t imem_addr;
    word_t imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a RAM response that arrives while decode is stalled.
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  clear_i,
    input  word_t pc_i,
    input  word_t instr_i,
    input  logic  adel_i,
    output logic  valid_o,
    output word_t pc_o,
    output word_t instr_o,
    output logic  adel_o
);

    logic  valid_q;
    word_t pc_q;
    word_t instr_q;
    logic  adel_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            adel_q  <= 1'b0;
        end else begin
            if (clear_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
                pc_q    <= pc_i;
                instr_q <= instr_i;
                adel_q  <= adel_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign adel_o  = adel_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with branch/exception redirect and a stall skid buffer.
// Optional `FETCH_ALIGN_CHECK_EN: misaligned fetch PCs raise id_adel instead of reading RAM.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t       RESET_PC = DefaultResetPc,
    parameter int unsigned EXC_PRIO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_redirect,
    input  word_t       br_pc,
    input  logic        exc_redirect,
    input  word_t       exc_pc,
    fetch_stage_if.master imem,
    output logic        id_valid,
    output word_t       pc,
    output word_t       pc_plus_4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  shmat,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [25:0] address,
    output logic        id_adel
);

    if (EXC_PRIO != 1) begin : gen_exc_prio_check
        $error("fetch_stage: only EXC_PRIO = 1 is supported");
    end

    fetch_state_e state_q, state_d;
    word_t fetch_pc_q, inflight_pc_q, id_pc_q, id_instr_q, resp_instr, target;
    logic  inflight_valid_q, inflight_adel_q, id_valid_q, id_adel_q;
    logic  redirect, fetch_req, fetch_en, adel_issue, id_load, skid_load, skid_clear;
    logic  skid_valid, skid_adel;
    word_t skid_pc, skid_instr;

    assign redirect  = exc_redirect | br_redirect;
    assign target    = exc_redirect ? exc_pc : br_pc;
    assign fetch_req = ~rst & (~stall | redirect) & ~skid_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned, halt_q;

    assign misaligned     = fetch_pc_q[1:0] != 2'b00;
    assign fetch_en       = fetch_req & ~misaligned;
    // A bad PC is reported once as a pseudo-response, then fetch parks until redirected.
    assign adel_issue     = fetch_req & misaligned & ~halt_q & ~redirect;
    assign imem.imem_addr = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            halt_q <= 1'b0;
        end else if (adel_issue) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign fetch_en       = fetch_req;
    assign adel_issue     = 1'b0;
    assign imem.imem_addr = {fetch_pc_q[31:2], 2'b00};
`endif

    assign imem.imem_en = fetch_en;
    assign resp_instr   = inflight_adel_q ? '0 : imem.imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q       <= RESET_PC;
            inflight_pc_q    <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_adel_q  <= 1'b0;
            state_q          <= FsRun;
        end else begin
            if (redirect) begin
                fetch_pc_q <= target;
            end else if (fetch_en) begin
                fetch_pc_q <= pc_inc(fetch_pc_q);
            end
            if (fetch_en || adel_issue) begin
                inflight_pc_q <= fetch_pc_q;
            end
            inflight_valid_q <= (fetch_en & ~redirect) | adel_issue;
            inflight_adel_q  <= adel_issue;
            state_q          <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_load    = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (redirect) begin
            state_d    = FsRun;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                FsRun: begin
                    if (!stall) begin
                        id_load = 1'b1;
                    end else if (inflight_valid_q) begin
                        skid_load = 1'b1;
                        state_d   = FsHold;
                    end
                end
                FsHold: begin
                    if (!stall) begin
                        id_load    = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = FsRun;
                    end
                end
                default: state_d = FsRun;
            endcase
        end
    end

    fetch_skid_buffer u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (inflight_pc_q),
        .instr_i (resp_instr),
        .adel_i  (inflight_adel_q),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr),
        .adel_o  (skid_adel)
    );

    // Payload only moves with a live instruction so fields stay stable across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
            id_pc_q    <= RESET_PC;
            id_instr_q <= '0;
        end else if (redirect) begin
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
        end else if (id_load) begin
            if (state_q == FsHold) begin
                id_valid_q <= skid_valid;
                id_adel_q  <= skid_adel;
                id_pc_q    <= skid_pc;
                id_instr_q <= skid_instr;
            end else begin
                id_valid_q <= inflight_valid_q;
                id_adel_q  <= inflight_adel_q;
                if (inflight_valid_q) begin
                    id_pc_q    <= inflight_pc_q;
                    id_instr_q <= resp_instr;
                end
            end
        end
    end

    assign id_valid  = id_valid_q;
    assign id_adel   = id_adel_q;
    assign pc        = id_pc_q;
    assign pc_plus_4 = pc_inc(id_pc_q);
    assign opcode    = id_instr_q[OpcodeLsb +: 6];
    assign rs        = id_instr_q[RsLsb +: 5];
    assign rt        = id_instr_q[RtLsb +: 5];
    assign rd        = id_instr_q[RdLsb +: 5];
    assign shmat     = {1'b0, id_instr_q[ShamtLsb +: 5]};
    assign funct     = id_instr_q[5:0];
    assign immediate = id_instr_q[15:0];
    assign address   = id_instr_q[25:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for run/stall/redirect, plus reset and alignment sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, br_redirect, exc_redirect;
    logic [31:0] br_pc, exc_pc, pc, pc_plus_4;
    logic        id_valid, id_adel;
    logic [5:0]  opcode, shmat, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] immediate;
    logic [25:0] address;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] Ins100 = 32'h8D2A_1234;

    fetch_stage_if mem_if ();

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_redirect  (br_redirect),
        .br_pc        (br_pc),
        .exc_redirect (exc_redirect),
        .exc_pc       (exc_pc),
        .imem         (mem_if),
        .id_valid     (id_valid),
        .pc           (pc),
        .pc_plus_4    (pc_plus_4),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shmat        (shmat),
        .funct        (funct),
        .immediate    (immediate),
        .address      (address),
        .id_adel      (id_adel)
    );

    always #5 clk = ~clk;

    // RAM word i holds i, except a real instruction at 0x100 to exercise the field split.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return Ins100;
        return {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) begin
        if (mem_if.imem_en) mem_if.imem_rdata <= mem_word(mem_if.imem_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_fields(input string name, input logic [31:0] ins);
        check(name, {opcode, rs, rt, rd, shmat, funct, immediate, address},
              {ins[31:26], ins[25:21], ins[20:16], ins[15:11], 1'b0, ins[10:6], ins[5:0],
               ins[15:0], ins[25:0]});
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] bpc,
                         input logic ex, input logic [31:0] epc);
        stall        = st;
        br_redirect  = br;
        br_pc        = bpc;
        exc_redirect = ex;
        exc_pc       = epc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        st, br, ex;
        logic [31:0] bpc, epc;
        logic        en;
        logic [31:0] addr;
        logic        valid, chk;
        logic [31:0] pc, ins;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bpc,
                                input logic ex, input logic [31:0] epc, input logic en,
                                input logic [31:0] addr, input logic valid, input logic chk,
                                input logic [31:0] p, input logic [31:0] ins);
        vec_t v;
        v.st = st; v.br = br; v.bpc = bpc; v.ex = ex; v.epc = epc; v.en = en; v.addr = addr;
        v.valid = valid; v.chk = chk; v.pc = p; v.ins = ins;
        return v;
    endfunction

    initial begin
        // Free run from reset, branch at pc 0x10 to 0x100
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h000, 0, 1, 32'h000, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h004, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h008, 1, 1, 32'h000, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h00C, 1, 1, 32'h004, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h010, 1, 1, 32'h008, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h014, 1, 1, 32'h00C, 3));
        vq.push_back(mk(0, 1, 32'h100, 0, 0, 1, 32'h018, 1, 1, 32'h010, 4));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h104, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h108, 1, 1, 32'h100, Ins100));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h10C, 1, 1, 32'h104, 32'h41));
        // Three-cycle stall, skid holds 0x10C
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h110, 1, 1, 32'h108, 32'h42));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h110, 1, 1, 32'h108, 32'h42));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h110, 1, 1, 32'h108, 32'h42));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h110, 1, 1, 32'h108, 32'h42));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h110, 1, 1, 32'h10C, 32'h43));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h114, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h118, 1, 1, 32'h110, 32'h44));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h11C, 1, 1, 32'h114, 32'h45));
        // Exception and branch together: exception target wins
        vq.push_back(mk(0, 1, 32'h200, 1, 32'h80, 1, 32'h120, 1, 1, 32'h118, 32'h46));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h080, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h084, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h088, 1, 1, 32'h080, 32'h20));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h08C, 1, 1, 32'h084, 32'h21));
        // Redirect while in HOLD with stall still high
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h090, 1, 1, 32'h088, 32'h22));
        vq.push_back(mk(1, 1, 32'h040, 0, 0, 0, 32'h090, 1, 1, 32'h088, 32'h22));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h040, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h044, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h048, 1, 1, 32'h040, 32'h10));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h04C, 1, 1, 32'h044, 32'h11));
        // Stall and redirect together in RUN: redirect still issues
        vq.push_back(mk(1, 1, 32'h00C, 0, 0, 1, 32'h050, 1, 1, 32'h048, 32'h12));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h00C, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h010, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h014, 1, 1, 32'h00C, 3));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].st, vq[i].br, vq[i].bpc, vq[i].ex, vq[i].epc);
            @(negedge clk);
            check($sformatf("v%0d imem_en", i), mem_if.imem_en, vq[i].en);
            check($sformatf("v%0d imem_addr", i), mem_if.imem_addr, vq[i].addr);
            check($sformatf("v%0d id_valid", i), id_valid, vq[i].valid);
            check($sformatf("v%0d id_adel", i), id_adel, 1'b0);
            if (vq[i].chk) begin
                check($sformatf("v%0d pc", i), pc, vq[i].pc);
                check($sformatf("v%0d pc_plus_4", i), pc_plus_4, vq[i].pc + 32'd4);
                check_fields($sformatf("v%0d fields", i), vq[i].ins);
            end
            next_cycle();
        end

        // Reset mid-operation discards the pending response
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst imem_en", mem_if.imem_en, 1'b0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst2 imem_addr", mem_if.imem_addr, 32'h0);
        check("rst2 imem_en", mem_if.imem_en, 1'b1);
        check("rst2 id_valid", id_valid, 1'b0);
        check("rst2 pc", pc, 32'h0);
        next_cycle();
        @(negedge clk);
        check("rst3 id_valid", id_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rst4 id_valid", id_valid, 1'b1);
        check("rst4 pc", pc, 32'h0);
        next_cycle();

        // Branch to a misaligned target
        drive(0, 1, 32'h102, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        check("adel1 imem_en", mem_if.imem_en, 1'b0);
`else
        check("adel1 imem_addr", mem_if.imem_addr, 32'h100);
`endif
        next_cycle();
        @(negedge clk);
        check("adel2 id_valid", id_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("adel3 id_valid", id_valid, 1'b1);
        check("adel3 pc", pc, 32'h102);
        check("adel3 pc_plus_4", pc_plus_4, 32'h106);
`ifdef FETCH_ALIGN_CHECK_EN
        check("adel3 id_adel", id_adel, 1'b1);
        check_fields("adel3 fields", 32'h0);
        check("adel3 imem_en", mem_if.imem_en, 1'b0);
        next_cycle();
        @(negedge clk);
        check("adel4 id_valid", id_valid, 1'b0);
        check("adel4 imem_en", mem_if.imem_en, 1'b0);
`else
        check("adel3 id_adel", id_adel, 1'b0);
        check_fields("adel3 fields", Ins100);
`endif
        next_cycle();
        drive(0, 1, 32'h020, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("adel5 imem_en", mem_if.imem_en, 1'b1);
        check("adel5 imem_addr", mem_if.imem_addr, 32'h020);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
